// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   DATA_WIDTH      - instruction-memory address/data width
//   BYTE_W          - width of one stream byte
//   HDR_BYTES       - bytes per little-endian field (count, word, checksum)
//   CNT_W           - width of the per-field byte counter
//   loader_state_e  - loader FSM state encodings
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHK state.
package imem_loader_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHK   = 3'd3,
`endif
        DONE  = 3'd4
    } loader_state_e;

    // True when the byte counter sits on the final byte of a 4-byte field.
    function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(HDR_BYTES - 1);
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: little-endian byte-to-word assembler.
//   clk, rst     - clock, asynchronous active-high reset
//   byte_in      - stream byte being accepted
//   valid        - byte_in is accepted this cycle
//   count        - position of byte_in within the current 4-byte field
//   word_c       - assembled word (combinational; complete when word_done_c)
//   word_done_c  - the fourth byte of a field is being accepted this cycle
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  valid,
    input  logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  word_done_c
);

    // Lower three bytes of the field; the top byte is taken straight from byte_in
    // so the full word is available in the same cycle as the last byte.
    logic [DATA_WIDTH-BYTE_W-1:0] low_q;

    // Byte capture: position is selected by the owner's byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_q <= '0;
        end else if (valid) begin
            case (count)
                2'd0:    low_q[7:0]   <= byte_in;
                2'd1:    low_q[15:8]  <= byte_in;
                2'd2:    low_q[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    assign word_c      = {byte_in, low_q};
    assign word_done_c = valid && is_last_byte(count);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a little-endian byte stream into instruction memory while
// holding the core stalled.
// Stream: 4-byte word count N, then N 4-byte words (then a 4-byte checksum when
// LOADER_CHECKSUM_EN is defined).
//   clk, rst       - clock, asynchronous active-high reset
//   s_valid/s_data - byte stream input; s_ready is the accept handshake
//   w_addr/w_dat   - instruction-memory write byte address and word
//   w_enb          - one-cycle write strobe
//   cpu_stall      - holds the core PC until the image is loaded
//   load_done      - image fully written
//   load_err       - checksum mismatch (constant 0 without LOADER_CHECKSUM_EN)
// Optional feature macro: LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic                  w_enb,
    output logic                  cpu_stall,
    output logic                  load_done,
    output logic                  load_err
);

    loader_state_e         state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [31:0]           word_cnt;
    logic [31:0]           word_idx;

    logic                  accept_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  word_done_c;
    logic                  in_range_c;
    logic                  last_word_c;
    logic [DATA_WIDTH-1:0] addr_c;

    assign accept_c    = s_valid & s_ready;
    assign in_range_c  = word_idx < MAX_WORDS;
    assign last_word_c = word_idx == (word_cnt - 32'd1);
    // Byte address of word i, wrapping modulo 2^32.
    assign addr_c      = BASE_ADDR + {word_idx[29:0], 2'b00};

    // Shared assembler for count, data words and checksum.
    loader_word_asm u_word_asm (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (s_data),
        .valid       (accept_c),
        .count       (byte_cnt),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // Loader FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            s_ready   <= 1'b1;
            w_enb     <= 1'b0;
            w_addr    <= '0;
            w_dat     <= '0;
            cpu_stall <= 1'b1;
            load_done <= 1'b0;
        end else begin
            w_enb <= 1'b0;
            // Counter wraps 3 -> 0 at each field boundary.
            if (accept_c) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            case (state)
                HDR: begin
                    if (word_done_c) begin
                        word_cnt <= word_c;
                        word_idx <= '0;
                        if (word_c == '0) begin
                            state     <= DONE;
                            s_ready   <= 1'b0;
                            cpu_stall <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_done_c) begin
                        state   <= WRITE;
                        s_ready <= 1'b0;
                        // Words beyond capacity are consumed but never written.
                        if (in_range_c) begin
                            w_enb  <= 1'b1;
                            w_addr <= addr_c;
                            w_dat  <= word_c;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 32'd1;
                    if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
                        state   <= CHK;
                        s_ready <= 1'b1;
`else
                        state     <= DONE;
                        cpu_stall <= 1'b0;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state   <= DATA;
                        s_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (word_done_c) begin
                        state     <= DONE;
                        s_ready   <= 1'b0;
                        cpu_stall <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
`endif
                DONE: ;
                default: begin
                    state   <= HDR;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running sum of every data word (written or not) and sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            load_err <= 1'b0;
        end else begin
            if (state == DATA && word_done_c) begin
                sum_q <= sum_q + word_c;
            end
            if (state == CHK && word_done_c && word_c != sum_q) begin
                load_err <= 1'b1;
            end
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
// (BASE_ADDR=0, MAX_WORDS=2). Checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic [31:0] w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .w_addr    (w_addr),
        .w_dat     (w_dat),
        .w_enb     (w_enb),
        .cpu_stall (cpu_stall),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (w_enb === 1'b1) begin
            wa.push_back(w_addr);
            wd.push_back(w_dat);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Offer one byte (called at a negedge); returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $error("FAIL byte_timeout: waited %0d cycles for s_ready, limit 50", n);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Little-endian word; gap idle cycles between bytes (none after the last).
    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0]);
            v = v >> 8;
            if (i < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_write_phase(input string tag, input logic exp_enb);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_enb"}, 32'(w_enb), 32'(exp_enb));
        check({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    endtask

    // Called at the last WRITE negedge; completes the load and checks DONE.
    task automatic finish_load(input string tag, input logic [31:0] sum);
        @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_chk_stall"}, 32'(cpu_stall), 32'd1);
        check({tag, "_chk_ready"}, 32'(s_ready), 32'd1);
        send_word(sum, 0);
`else
        check({tag, "_sum_unused"}, sum, sum);
`endif
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_stall_low"}, 32'(cpu_stall), 32'd0);
        check({tag, "_ready_low"}, 32'(s_ready), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        wa.delete();
        wd.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset values while rst is held.
        @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_enb", 32'(w_enb), 32'd0);
        check("rst_addr", w_addr, 32'h0);
        check("rst_dat", w_dat, 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // N=0: DONE right after the 4th header byte, no writes, held.
        send_word(32'h0, 0);
        check("n0_done", 32'(load_done), 32'd1);
        check("n0_stall", 32'(cpu_stall), 32'd0);
        check("n0_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("n0_hold_done", 32'(load_done), 32'd1);
        check("n0_hold_ready", 32'(s_ready), 32'd0);
        check("n0_writes", 32'(wa.size()), 32'd0);

        // N=2, back-to-back bytes.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h0050_0093, 0);
        check_write_phase("n2_w0", 1'b1);
        send_word(32'h00A0_0113, 0);
        check_write_phase("n2_w1", 1'b1);
        finish_load("n2", 32'h00F0_01A6);
        check("n2_writes", 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            check("n2_a0", wa[0], 32'h0000_0000);
            check("n2_d0", wd[0], 32'h0050_0093);
            check("n2_a1", wa[1], 32'h0000_0004);
            check("n2_d1", wd[1], 32'h00A0_0113);
        end

        // Same image with s_valid dropping between every byte.
        do_reset();
        send_word(32'd2, 1);
        send_word(32'h0050_0093, 1);
        check_write_phase("tg_w0", 1'b1);
        send_word(32'h00A0_0113, 1);
        check_write_phase("tg_w1", 1'b1);
        finish_load("tg", 32'h00F0_01A6);
        check("tg_writes", 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            check("tg_a0", wa[0], 32'h0000_0000);
            check("tg_d0", wd[0], 32'h0050_0093);
            check("tg_a1", wa[1], 32'h0000_0004);
            check("tg_d1", wd[1], 32'h00A0_0113);
        end

        // N=3 with capacity 2: third word consumed but not written.
        do_reset();
        send_word(32'd3, 0);
        send_word(32'h1111_1111, 0);
        check_write_phase("cap_w0", 1'b1);
        send_word(32'h2222_2222, 0);
        check_write_phase("cap_w1", 1'b1);
        send_word(32'h3333_3333, 0);
        check_write_phase("cap_w2", 1'b0);
        finish_load("cap", 32'h6666_6666);
        check("cap_writes", 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            check("cap_a1", wa[1], 32'h0000_0004);
            check("cap_d1", wd[1], 32'h2222_2222);
        end

        // Reset after 6 bytes, then a fresh N=1 image.
        do_reset();
        send_word(32'd2, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 32'(cpu_stall), 32'd1);
        check("mid_rst_ready", 32'(s_ready), 32'd1);
        check("mid_rst_done", 32'(load_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        check_write_phase("mid_w0", 1'b1);
        finish_load("mid", 32'hDEAD_BEEF);
        check("mid_writes", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check("mid_a0", wa[0], 32'h0000_0000);
            check("mid_d0", wd[0], 32'hDEAD_BEEF);
        end

`ifdef LOADER_CHECKSUM_EN
        // Matching checksum.
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h1234_5678, 0);
        check_write_phase("ck_ok_w0", 1'b1);
        finish_load("ck_ok", 32'h1234_5678);

        // Mismatching checksum: sticky error.
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h1234_5678, 0);
        @(negedge clk);
        send_word(32'h1234_5679, 0);
        check("ck_bad_done", 32'(load_done), 32'd1);
        check("ck_bad_err", 32'(load_err), 32'd1);
        repeat (4) @(negedge clk);
        check("ck_bad_err_sticky", 32'(load_err), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024: instruction-memory capacity in 32-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: a byte is offered on s_data.
REQ-006 The block SHALL have port s_data, input, 8 bits: the byte-stream payload.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 The block SHALL have port w_addr, output, DATA_WIDTH bits: the instruction-memory write byte address.
REQ-009 The block SHALL have port w_dat, output, DATA_WIDTH bits: the instruction-memory write word.
REQ-010 The block SHALL have port w_enb, output, 1 bit: the instruction-memory write strobe.
REQ-011 The block SHALL have port cpu_stall, output, 1 bit: holds the core's PC while loading; drives the PC stall input.
REQ-012 The block SHALL have port load_done, output, 1 bit: the image is fully written.
REQ-013 The block SHALL have port load_err, output, 1 bit: checksum mismatch (see REQ-031).

Function
REQ-014 A byte SHALL be accepted only in a cycle where s_valid and s_ready are both high.
REQ-015 The stream format SHALL be a 4-byte little-endian word count N, followed by N words, each 4 bytes little-endian.
REQ-016 The FSM SHALL have states HDR (collect N), DATA (collect word bytes), WRITE (one-cycle strobe), CHK (present only with REQ-031) and DONE.
REQ-017 s_ready SHALL be high in HDR, DATA and CHK, and low in WRITE and DONE.
REQ-018 On acceptance of the 4th HDR byte, the FSM SHALL go to DONE if N==0, otherwise to DATA.
REQ-019 On acceptance of the 4th byte of word i, the FSM SHALL enter WRITE on the next cycle.
REQ-020 In WRITE, w_enb SHALL be high for exactly one cycle, with w_addr=BASE_ADDR+4*i (mod 2^32) and w_dat equal to the assembled word.
REQ-021 From WRITE, the FSM SHALL return to DATA if i+1<N, otherwise go to CHK (if enabled) or DONE.
REQ-022 Words with i>=MAX_WORDS SHALL be consumed and sequenced normally, but w_enb SHALL stay low for them (no wrap into low memory).
REQ-023 The word index SHALL be 32 bits wide, so N up to 2^32-1 is sequenced without overflow.
REQ-024 cpu_stall SHALL be high in every state except DONE.
REQ-025 In DONE, load_done SHALL be high, cpu_stall low and s_ready low, and DONE SHALL be held until reset.
REQ-026 Outside WRITE, w_enb SHALL be 0, and w_addr/w_dat SHALL hold their last driven values.
REQ-027 s_valid low mid-word SHALL stall byte assembly with no loss of partial bytes.

Reset
REQ-028 While rst is high: state=HDR, byte counter=0, word index=0, s_ready=1, w_enb=0, w_addr=0, w_dat=0, cpu_stall=1, load_done=0, load_err=0.
REQ-029 rst asserted mid-load SHALL discard partial words and restart at HDR; words already written SHALL be left in memory.
REQ-030 The first byte after rst deassertion SHALL be treated as HDR byte 0.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined: after the last word, CHK SHALL accept a 4-byte little-endian checksum C, then enter DONE; load_err SHALL be set high (sticky until reset) iff C differs from the sum of all N words mod 2^32 (written or not).
REQ-032 Without LOADER_CHECKSUM_EN: the CHK state and checksum adder SHALL be absent, and load_err SHALL be constant 0.

Structure
REQ-033 State encodings, HDR_BYTES=4 and the byte width SHALL live in a shared loader include; DATA_WIDTH SHALL come from the existing parameter include.
REQ-034 Byte-to-word little-endian assembly SHALL be one sub-module, loader_word_asm (byte in, valid, 2-bit count, word out, word_done).

Verification
REQ-035 Bytes 00 00 00 00 -> DONE one cycle after the 4th byte; no w_enb; load_done=1.
REQ-036 N=2, words 0x00500093 and 0x00A00113 -> w_enb at addr 0x0 then 0x4 with those data; cpu_stall falls after the second WRITE.
REQ-037 s_valid toggled every other cycle during a word -> identical writes; s_ready low during each WRITE cycle.
REQ-038 MAX_WORDS=2, N=3 -> only two writes; third word consumed; load_done=1.
REQ-039 rst pulsed after 6 bytes -> state HDR, cpu_stall=1; a fresh N=1 stream writes addr BASE_ADDR.
REQ-040 LOADER_CHECKSUM_EN, N=1, word 0x12345678, checksum 0x12345678 -> load_err=0; checksum 0x12345679 -> load_err=1.
